uart_transmit: RTL and testbench

//   8N1 UART transmitter: serialises one byte per request onto tx_o, LSB first.
//   It is the transmit end of the link whose receive end is uart_receive.

---
 rtl/uart_transmit.sv | 161 ++++++++++++++++
 tb/tb_uart_transmit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: serialises one byte per accepted request onto tx_o, LSB first.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_transmit #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       send,
   output logic       ready,
   output logic       done,
   output logic       tx_o
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic ParityOdd    = 1'(PARITY_ODD);
`endif

   localparam logic [15:0] LastCnt     = 16'(CLKS_PER_BIT - 1);
   // STOP leaves one cycle early so ready/done land in the final stop-bit cycle
   // and a held send starts the next frame with no extra idle cycle.
   localparam logic [15:0] StopLastCnt = 16'(CLKS_PER_BIT - 2);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : gIllegalParams
   end

   logic [2:0]  state_q,   state_d;
   logic [15:0] baudCnt_q, baudCnt_d;
   logic [2:0]  bitIdx_q,  bitIdx_d;
   logic [7:0]  shift_q,   shift_d;
   logic        tx_q,      tx_d;
   logic        ready_q,   ready_d;
   logic        done_q,    done_d;
`ifdef UART_TX_PARITY_EN
   logic        parity_q,  parity_d;
`endif
   logic        bitEnd;

   assign bitEnd = (baudCnt_q == LastCnt);

   always_comb begin
      state_d   = state_q;
      baudCnt_d = baudCnt_q;
      bitIdx_d  = bitIdx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      ready_d   = ready_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         IDLE: begin
            baudCnt_d = '0;
            if (send && ready_q) begin
               shift_d = data;
               state_d = START;
               tx_d    = 1'b0;
               ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
               parity_d = (^data) ^ ParityOdd;
`endif
            end
         end
         START: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               bitIdx_d  = '0;
               state_d   = DATA;
               tx_d      = shift_q[0];
            end else begin
               baudCnt_d = baudCnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               bitIdx_d  = bitIdx_q + 3'd1;
               if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = parity_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  tx_d = shift_q[1];
               end
            end else begin
               baudCnt_d = baudCnt_q + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bitEnd) begin
               baudCnt_d = '0;
               state_d   = STOP;
               tx_d      = 1'b1;
            end else begin
               baudCnt_d = baudCnt_q + 16'd1;
            end
         end
`endif
         STOP: begin
            if (baudCnt_q == StopLastCnt) begin
               baudCnt_d = '0;
               state_d   = IDLE;
               ready_d   = 1'b1;
               done_d    = 1'b1;
            end else begin
               baudCnt_d = baudCnt_q + 16'd1;
            end
         end
         default: begin
            state_d   = IDLE;
            baudCnt_d = '0;
            tx_d      = 1'b1;
            ready_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         baudCnt_q <= '0;
         bitIdx_q  <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baudCnt_q <= baudCnt_d;
         bitIdx_q  <= bitIdx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign tx_o  = tx_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit (CLKS_PER_BIT=4): a scoreboard of expected
// bytes is checked bit-by-bit against tx_o, with done/ready timing per frame.
module tb_uart_transmit;

   localparam int CPB = 4;
   localparam logic TbParityOdd = 1'b0;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       send = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready;
   logic       done;
   logic       tx_o;

   int checkCount = 0;
   int errorCount = 0;
   int cycleCount = 0;
   int doneCount = 0;

   logic [7:0]       expQ[$];
   bit               monActive = 1'b0;
   int               monPos = 0;
   logic [NBITS-1:0] frameBits = '1;
   int               lastStart = -1;
   int               prevStart = -1;

   uart_transmit #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
      .clk  (clk),
      .reset(reset),
      .data (data),
      .send (send),
      .ready(ready),
      .done (done),
      .tx_o (tx_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, observed, expected, cycleCount);
      end
   endtask

   function automatic logic [NBITS-1:0] buildFrame(input logic [7:0] b);
      logic [NBITS-1:0] f;
      f          = '1;
      f[0]       = 1'b0;
      f[8:1]     = b;
`ifdef UART_TX_PARITY_EN
      f[9]       = (^b) ^ TbParityOdd;
`endif
      f[NBITS-1] = 1'b1;
      return f;
   endfunction

   // Frame monitor: a falling tx_o while idle starts a frame, which is then
   // compared cycle by cycle against the next byte in the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         monActive = 1'b0;
      end else begin
         if (done === 1'b1) doneCount++;
         if (!monActive && tx_o === 1'b0) begin
            checkOutput("queueOnStart", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) frameBits = buildFrame(expQ.pop_front());
            monActive = 1'b1;
            monPos    = 0;
            prevStart = lastStart;
            lastStart = cycleCount;
         end
         if (monActive) begin
            checkOutput("txBit", 32'(tx_o), 32'(frameBits[monPos / CPB]));
            checkOutput("frameDone", 32'(done), 32'(monPos == FRAME - 1));
            checkOutput("frameReady", 32'(ready), 32'(monPos == FRAME - 1));
            monPos++;
            if (monPos == FRAME) monActive = 1'b0;
         end else begin
            checkOutput("idleTx", 32'(tx_o), 1);
            checkOutput("idleDone", 32'(done), 0);
            checkOutput("idleReady", 32'(ready), 1);
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input bit expectAccept);
      @(posedge clk);
      #1;
      data = b;
      send = 1'b1;
      if (expectAccept) expQ.push_back(b);
      @(posedge clk);
      #1;
      send = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || monActive) && n < 400) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idleTimeout", 32'(n < 400), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int d0;

      // Reset held with send=1: line must stay idle and nothing may start.
      #1;
      reset = 1'b1;
      send  = 1'b1;
      data  = 8'h55;
      repeat (3) @(negedge clk);
      checkOutput("rstTx", 32'(tx_o), 1);
      checkOutput("rstReady", 32'(ready), 1);
      checkOutput("rstDone", 32'(done), 0);
      @(posedge clk);
      #1;
      send = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(negedge clk);

      $display("[TB] single byte 0x55");
      d0 = doneCount;
      applyStimulus(8'h55, 1'b1);
      waitIdle();
      checkOutput("doneCount55", d0 + 1, doneCount);

      $display("[TB] busy ignore 0xA5 / 0xFF");
      d0 = doneCount;
      applyStimulus(8'hA5, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      data = 8'hFF;
      send = 1'b1;
      @(posedge clk);
      #1;
      send = 1'b0;
      waitIdle();
      repeat (20) @(negedge clk);
      checkOutput("doneCountBusy", d0 + 1, doneCount);

      $display("[TB] back-to-back 0xA5, 0x3C");
      d0 = doneCount;
      @(posedge clk);
      #1;
      data = 8'hA5;
      send = 1'b1;
      expQ.push_back(8'hA5);
      expQ.push_back(8'h3C);
      @(posedge clk);
      #1;
      data = 8'h3C;
      repeat (40) @(posedge clk);
      #1;
      send = 1'b0;
      waitIdle();
      checkOutput("doneCountB2B", d0 + 2, doneCount);
      checkOutput("b2bGap", lastStart - prevStart, FRAME);

      $display("[TB] reset mid-frame 0x00, then 0x81");
      d0 = doneCount;
      applyStimulus(8'h00, 1'b1);
      repeat (16) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midRstTx", 32'(tx_o), 1);
      checkOutput("midRstReady", 32'(ready), 1);
      checkOutput("midRstDone", 32'(done), 0);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (50) @(negedge clk);
      checkOutput("doneAfterAbort", d0, doneCount);
      d0 = doneCount;
      applyStimulus(8'h81, 1'b1);
      waitIdle();
      checkOutput("doneCount81", d0 + 1, doneCount);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
